// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA path: default 640x480@60 geometry,
// derived totals and sync windows, and the coordinate type used by downstream logic.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam int   DEF_CLK_DIV  = 2;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // Inclusive window test used for the sync decodes.
    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Pixel-rate divider: counts clk cycles per pixel while enabled, producing the
// position advance strobe and a registered ~50% duty pixel_tick.
module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic advance,
    output logic pixel_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             pixel_tick_reg;

    assign advance    = enable && (div_cnt_reg == DIV_LAST);
    assign pixel_tick = pixel_tick_reg;

    always_comb begin
        div_cnt_next = div_cnt_reg;
        if (enable) begin
            div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
        end
    end

    // The tick follows the next count so it rises CLK_DIV/2 clks after each advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg    <= '0;
            pixel_tick_reg <= 1'b0;
        end else begin
            div_cnt_reg    <= div_cnt_next;
            pixel_tick_reg <= enable && (div_cnt_next >= DIV_HALF);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: scans pixel_x/pixel_y over the full frame at the pixel
// rate and emits registered video_on, sync and line/frame start markers.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               pixel_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS_END = coord_t'(V_ACTIVE);
    localparam coord_t H_SYNC_LO = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_LO = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic   advance;
    coord_t x_reg, x_next;
    coord_t y_reg, y_next;
    logic   video_on_reg, hsync_reg, vsync_reg;
    logic   line_start_reg, frame_start_reg;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .advance    (advance),
        .pixel_tick (pixel_tick)
    );

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (advance) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                y_next = (y_reg == V_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    // Reset parks the scan on the last blanking position so the first advance lands on (0,0).
    // Decodes use the next-state counters so they switch on the same edge as the position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg           <= H_LAST;
            y_reg           <= V_LAST;
            video_on_reg    <= 1'b0;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            video_on_reg    <= (x_next < H_VIS_END) && (y_next < V_VIS_END);
            hsync_reg       <= in_span(x_next, H_SYNC_LO, H_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
            vsync_reg       <= in_span(y_next, V_SYNC_LO, V_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
            line_start_reg  <= advance && (x_next == '0);
            frame_start_reg <= advance && (x_next == '0) && (y_next == '0);
        end
    end

    assign pixel_x     = x_reg;
    assign pixel_y     = y_reg;
    assign video_on    = video_on_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a tiny-geometry instance,
// each checked cycle by cycle against an arithmetic raster model via a scoreboard.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, en_a, tick_a, vo_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       rst_b_n, en_b, tick_b, vo_b, hs_b, vs_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;

    vga_sync_gen dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .enable      (en_a),
        .pixel_tick  (tick_a),
        .pixel_x     (x_a),
        .pixel_y     (y_a),
        .video_on    (vo_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .CLK_DIV  (4), .SYNC_POL (1'b1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .enable      (en_b),
        .pixel_tick  (tick_b),
        .pixel_x     (x_b),
        .pixel_y     (y_b),
        .video_on    (vo_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } vga_t;

    int p_ha[2]  = '{640, 8};
    int p_hf[2]  = '{16, 1};
    int p_hs[2]  = '{96, 2};
    int p_hb[2]  = '{48, 1};
    int p_va[2]  = '{480, 4};
    int p_vf[2]  = '{10, 1};
    int p_vs[2]  = '{2, 1};
    int p_vb[2]  = '{33, 1};
    int p_div[2] = '{2, 4};
    bit p_pol[2] = '{1'b0, 1'b1};

    int ecnt[2];
    bit len[2];
    int cnt[2];
    int last_ls[2];
    int last_fs[2];
    int ls_period[2];
    int fs_period[2];
    int ls_cnt[2];
    int fs_cnt[2];
    int hs_act[2];
    int vs_act[2];
    int vo_low[2];
    int tick_hi[2];

    vga_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   found;

    // Position follows from the count of enabled edges alone: k advances from (H-1,V-1).
    function automatic vga_t model(input int s, input int e, input bit le);
        vga_t r;
        int   ht, vt, k, ph, idx, x, y, hlo, vlo;
        bit   pol;
        ht  = p_ha[s] + p_hf[s] + p_hs[s] + p_hb[s];
        vt  = p_va[s] + p_vf[s] + p_vs[s] + p_vb[s];
        k   = e / p_div[s];
        ph  = e % p_div[s];
        idx = (k + ht * vt - 1) % (ht * vt);
        x   = idx % ht;
        y   = idx / ht;
        hlo = p_ha[s] + p_hf[s];
        vlo = p_va[s] + p_vf[s];
        pol = p_pol[s];
        r.tick = le && (ph >= p_div[s] / 2);
        r.x    = x[9:0];
        r.y    = y[9:0];
        r.vo   = (x < p_ha[s]) && (y < p_va[s]);
        r.hs   = (x >= hlo && x < hlo + p_hs[s]) ? pol : ~pol;
        r.vs   = (y >= vlo && y < vlo + p_vs[s]) ? pol : ~pol;
        r.ls   = le && (ph == 0) && (k > 0) && (x == 0);
        r.fs   = r.ls && (y == 0);
        return r;
    endfunction

    function automatic vga_t observe(input int s);
        vga_t o;
        if (s == 0) o = {tick_a, x_a, y_a, vo_a, hs_a, vs_a, ls_a, fs_a};
        else        o = {tick_b, x_b, y_b, vo_b, hs_b, vs_b, ls_b, fs_b};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic score(input int s, input string tag);
        vga_t e;
        vga_t o;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            o = observe(s);
            chk(tag, {6'b0, o}, {6'b0, e});
        end
    endtask

    task automatic check_now(input int s, input string tag);
        exp_q.push_back(model(s, ecnt[s], len[s]));
        score(s, tag);
    endtask

    task automatic clear_stats(input int s);
        ls_cnt[s]  = 0;
        fs_cnt[s]  = 0;
        hs_act[s]  = 0;
        vs_act[s]  = 0;
        vo_low[s]  = 0;
        tick_hi[s] = 0;
    endtask

    task automatic restart_model(input int s);
        ecnt[s]    = 0;
        len[s]     = 1'b0;
        last_ls[s] = -1;
        last_fs[s] = -1;
    endtask

    task automatic cyc(input int s);
        bit   en;
        vga_t o;
        en = (s == 0) ? en_a : en_b;
        if (en) ecnt[s]++;
        len[s] = en;
        exp_q.push_back(model(s, ecnt[s], len[s]));
        @(posedge clk);
        #1;
        if (s == 0) score(s, "scan_a");
        else        score(s, "scan_b");
        o = observe(s);
        cnt[s]++;
        if (o.tick) tick_hi[s]++;
        if (!o.vo) vo_low[s]++;
        if (o.hs == p_pol[s]) hs_act[s]++;
        if (o.vs == p_pol[s]) vs_act[s]++;
        if (o.ls) begin
            ls_cnt[s]++;
            if (last_ls[s] >= 0) ls_period[s] = cnt[s] - last_ls[s];
            last_ls[s] = cnt[s];
        end
        if (o.fs) begin
            fs_cnt[s]++;
            if (last_fs[s] >= 0) fs_period[s] = cnt[s] - last_fs[s];
            last_fs[s] = cnt[s];
        end
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        en_a    = 1'b1;
        en_b    = 1'b1;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #3;

        // Default geometry: release and first-advance timing.
        rst_a_n = 1'b1;
        restart_model(0);
        check_now(0, "reset_a");
        chk("reset_a_hsync", hs_a, 1);
        cyc(0);
        chk("edge1_tick", tick_a, 1);
        cyc(0);
        chk("edge2_frame_start", fs_a, 1);
        chk("edge2_line_start", ls_a, 1);
        chk("edge2_video_on", vo_a, 1);

        // One full line from a line start to the next.
        clear_stats(0);
        for (int i = 0; i < 1600; i++) cyc(0);
        chk("line_ls_count", ls_cnt[0], 1);
        chk("line_ls_at_end", ls_a, 1);
        chk("line_hsync_clks", hs_act[0], 192);
        chk("line_blank_clks", vo_low[0], 320);

        // Hold the scan for 37 clks at pixel_x=300.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cyc(0);
            if (x_a == 10'd300) found = 1'b1;
        end
        chk("reach_x300", found, 1);
        en_a = 1'b0;
        clear_stats(0);
        for (int i = 0; i < 37; i++) cyc(0);
        chk("hold_x", x_a, 300);
        chk("hold_tick_clks", tick_hi[0], 0);
        chk("hold_line_start", ls_cnt[0], 0);
        en_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cyc(0);
            if (ls_a) found = 1'b1;
        end
        chk("reach_next_line", found, 1);
        chk("stretched_line_clks", ls_period[0], 1637);

        // Asynchronous reset between edges, then the first-advance sequence again.
        for (int i = 0; i < 501; i++) cyc(0);
        #2;
        rst_a_n = 1'b0;
        restart_model(0);
        #1;
        check_now(0, "async_reset");
        chk("async_reset_x", x_a, 799);
        #2;
        rst_a_n = 1'b1;
        cyc(0);
        chk("rerun_edge1_tick", tick_a, 1);
        cyc(0);
        chk("rerun_edge2_frame_start", fs_a, 1);
        for (int i = 0; i < 20; i++) cyc(0);

        // Small geometry, CLK_DIV=4, positive syncs.
        rst_b_n = 1'b1;
        restart_model(1);
        check_now(1, "reset_b");
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (fs_b) found = 1'b1;
        end
        chk("b_first_frame", found, 1);
        clear_stats(1);
        for (int i = 0; i < 336; i++) cyc(1);
        chk("b_frame_start_count", fs_cnt[1], 1);
        chk("b_frame_clks", fs_period[1], 336);
        chk("b_tick_clks", tick_hi[1], 168);
        chk("b_vsync_clks", vs_act[1], 48);
        chk("b_hsync_clks", hs_act[1], 56);
        for (int i = 0; i < 100; i++) cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
